// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with an optional second (skid) entry so that in_ready_o
// can be registered. Words leave strictly in acceptance order.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W     = 32,
  parameter bit                   SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic main_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  // With the skid entry, ready depends only on local state, never on out_ready_i.
  always_comb begin
    if (SKID_EN) begin
      in_ready_o = ~skid_v & ~stall_i;
    end else begin
      in_ready_o = (~main_v | out_ready_i) & ~stall_i;
    end
  end

  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = main_v & out_ready_i & ~stall_i;
  assign out_valid_o = main_v;
  assign out_data_o  = main_data_q;

  always_comb begin
    count_o = 2'd0;
    case (state_q)
      EMPTY:   count_o = 2'd0;
      ONE:     count_o = 2'd1;
      FULL:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  // Payload registers only change on an actual transfer, keeping out_data_o stable under backpressure.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data_i;
          end else if (in_fire) begin
            if (SKID_EN) begin
              state_d     = FULL;
              skid_data_d = in_data_i;
            end
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_DATA;
      skid_data_q <= RESET_DATA;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table on a skid instance, a hand
// sequence on a pass-through instance, then random traffic against queue models.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Skid instance (DATA_W=32, RESET_DATA=0x5A)
  logic        s_rst, s_stall, s_flush, s_iv, s_ordy;
  logic [31:0] s_data;
  logic        s_ready, s_valid;
  logic [31:0] s_odata;
  logic [1:0]  s_count;

  // Pass-through instance (DATA_W=8)
  logic        p_rst, p_stall, p_flush, p_iv, p_ordy;
  logic [7:0]  p_data;
  logic        p_ready, p_valid;
  logic [7:0]  p_odata;
  logic [1:0]  p_count;

  pipe_stage_skid #(.DATA_W(32), .SKID_EN(1'b1), .RESET_DATA(32'h5A)) u_skid (
    .clk(clk), .rst(s_rst), .stall_i(s_stall), .flush_i(s_flush),
    .in_valid_i(s_iv), .in_ready_o(s_ready), .in_data_i(s_data),
    .out_valid_o(s_valid), .out_ready_i(s_ordy), .out_data_o(s_odata),
    .count_o(s_count)
  );

  pipe_stage_skid #(.DATA_W(8), .SKID_EN(1'b0), .RESET_DATA(8'h00)) u_pass (
    .clk(clk), .rst(p_rst), .stall_i(p_stall), .flush_i(p_flush),
    .in_valid_i(p_iv), .in_ready_o(p_ready), .in_data_i(p_data),
    .out_valid_o(p_valid), .out_ready_i(p_ordy), .out_data_o(p_odata),
    .count_o(p_count)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          rst, stall, flush, iv;
    logic [31:0] data;
    bit          ordy;
    bit          ev;
    logic [31:0] ed;
    bit          chk_d;
    logic [1:0]  ec;
    bit          er;
  } vec_t;

  vec_t tbl[$];

  logic [31:0] sq[$];
  logic [7:0]  pq[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic addRow(input bit rst, input bit stall, input bit flush, input bit iv,
                        input logic [31:0] data, input bit ordy, input bit ev,
                        input logic [31:0] ed, input bit chk_d, input logic [1:0] ec,
                        input bit er);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.iv = iv; v.data = data;
    v.ordy = ordy; v.ev = ev; v.ed = ed; v.chk_d = chk_d; v.ec = ec; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic idlePass(input bit rst);
    p_rst = rst; p_stall = 1'b0; p_flush = 1'b0; p_iv = 1'b0; p_data = 8'h0; p_ordy = 1'b0;
  endtask

  task automatic idleSkid(input bit rst);
    s_rst = rst; s_stall = 1'b0; s_flush = 1'b0; s_iv = 1'b0; s_data = 32'h0; s_ordy = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One random cycle on both instances, checked against FIFO queue models.
  task automatic applyStimulus(input int cyc);
    bit s_mready, p_mready, s_in_f, s_out_f, p_in_f, p_out_f;
    s_rst   = ($urandom_range(0, 79) == 0);
    s_stall = ($urandom_range(0, 4) == 0);
    s_flush = ($urandom_range(0, 19) == 0);
    s_iv    = ($urandom_range(0, 9) < 7);
    s_ordy  = ($urandom_range(0, 9) < 6);
    s_data  = $urandom;
    p_rst   = ($urandom_range(0, 79) == 0);
    p_stall = ($urandom_range(0, 4) == 0);
    p_flush = ($urandom_range(0, 19) == 0);
    p_iv    = ($urandom_range(0, 9) < 7);
    p_ordy  = ($urandom_range(0, 9) < 6);
    p_data  = 8'($urandom);
    #1;
    s_mready = (sq.size() < 2) && !s_stall;
    p_mready = ((pq.size() == 0) || p_ordy) && !p_stall;
    checkOutput($sformatf("rnd%0d_s_valid", cyc), 32'(s_valid), 32'(sq.size() > 0));
    checkOutput($sformatf("rnd%0d_s_count", cyc), 32'(s_count), 32'(sq.size()));
    checkOutput($sformatf("rnd%0d_s_ready", cyc), 32'(s_ready), 32'(s_mready));
    if (sq.size() > 0) checkOutput($sformatf("rnd%0d_s_data", cyc), s_odata, sq[0]);
    checkOutput($sformatf("rnd%0d_p_valid", cyc), 32'(p_valid), 32'(pq.size() > 0));
    checkOutput($sformatf("rnd%0d_p_count", cyc), 32'(p_count), 32'(pq.size()));
    checkOutput($sformatf("rnd%0d_p_ready", cyc), 32'(p_ready), 32'(p_mready));
    checkOutput($sformatf("rnd%0d_p_count_le1", cyc), 32'(p_count <= 2'd1), 32'd1);
    if (pq.size() > 0) checkOutput($sformatf("rnd%0d_p_data", cyc), 32'(p_odata), 32'(pq[0]));
    s_in_f  = s_iv && s_mready;
    s_out_f = (sq.size() > 0) && s_ordy && !s_stall;
    p_in_f  = p_iv && p_mready;
    p_out_f = (pq.size() > 0) && p_ordy && !p_stall;
    @(posedge clk);
    if (s_rst || s_flush) sq.delete();
    else begin
      if (s_out_f) void'(sq.pop_front());
      if (s_in_f) sq.push_back(s_data);
    end
    if (p_rst || p_flush) pq.delete();
    else begin
      if (p_out_f) void'(pq.pop_front());
      if (p_in_f) pq.push_back(p_data);
    end
    #1;
  endtask

  initial begin
    idleSkid(1'b1);
    idlePass(1'b1);
    nextCycle();
    s_rst = 1'b0;

    // Directed table on the skid instance; expectations are pre-edge outputs.
    addRow(0,0,0,0,32'h0,1, 0,32'h5A,1,2'd0,1);
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) addRow(0,0,0,1,32'(i),1, 0,32'h5A,1,2'd0,1);
      else        addRow(0,0,0,1,32'(i),1, 1,32'(i-1),1,2'd1,1);
    end
    addRow(0,0,0,0,32'h0,1,  1,32'h8,1,2'd1,1);
    addRow(0,0,0,1,32'hA,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hB,0,  1,32'hA,1,2'd1,1);
    addRow(0,0,0,1,32'hEE,0, 1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,1,  1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,1,  1,32'hB,1,2'd1,1);
    addRow(0,0,0,0,32'h0,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hA,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hB,0,  1,32'hA,1,2'd1,1);
    for (int i = 0; i < 3; i++) addRow(0,1,0,1,32'h77,1, 1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,1,  1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,1,  1,32'hB,1,2'd1,1);
    addRow(0,0,0,0,32'h0,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hA,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hB,0,  1,32'hA,1,2'd1,1);
    addRow(0,0,1,1,32'hC,0,  1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hD,0,  0,32'h0,0,2'd0,1);
    addRow(0,1,1,1,32'hC,1,  1,32'hD,1,2'd1,0);
    addRow(0,0,0,1,32'hE,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,1,1,32'hC,1,  1,32'hE,1,2'd1,1);
    addRow(0,0,0,0,32'h0,1,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hA,0,  0,32'h0,0,2'd0,1);
    addRow(0,0,0,1,32'hB,0,  1,32'hA,1,2'd1,1);
    addRow(1,0,0,1,32'hC,1,  1,32'hA,1,2'd2,0);
    addRow(0,0,0,0,32'h0,0,  0,32'h5A,1,2'd0,1);
    addRow(0,0,0,1,32'hF,0,  0,32'h5A,1,2'd0,1);
    addRow(1,1,1,0,32'h0,0,  1,32'hF,1,2'd1,0);
    addRow(0,0,0,0,32'h0,0,  0,32'h5A,1,2'd0,1);

    foreach (tbl[i]) begin
      s_rst = tbl[i].rst; s_stall = tbl[i].stall; s_flush = tbl[i].flush;
      s_iv = tbl[i].iv; s_data = tbl[i].data; s_ordy = tbl[i].ordy;
      #1;
      checkOutput($sformatf("row%0d_valid", i), 32'(s_valid), 32'(tbl[i].ev));
      checkOutput($sformatf("row%0d_count", i), 32'(s_count), 32'(tbl[i].ec));
      checkOutput($sformatf("row%0d_ready", i), 32'(s_ready), 32'(tbl[i].er));
      if (tbl[i].chk_d) checkOutput($sformatf("row%0d_data", i), s_odata, tbl[i].ed);
      nextCycle();
    end
    idleSkid(1'b0);

    // Pass-through instance: ready follows out_ready_i combinationally while occupied.
    idlePass(1'b0);
    #1;
    checkOutput("pt_ready_empty", 32'(p_ready), 32'd1);
    checkOutput("pt_count_reset", 32'(p_count), 32'd0);
    nextCycle();
    p_iv = 1'b1; p_data = 8'h11; p_ordy = 1'b0;
    #1;
    checkOutput("pt_ready_load", 32'(p_ready), 32'd1);
    nextCycle();
    p_data = 8'h22;
    #1;
    checkOutput("pt_ready_blocked", 32'(p_ready), 32'd0);
    checkOutput("pt_data_11", 32'(p_odata), 32'h11);
    checkOutput("pt_count_one", 32'(p_count), 32'd1);
    p_ordy = 1'b1;
    #1;
    checkOutput("pt_ready_follows", 32'(p_ready), 32'd1);
    nextCycle();
    p_data = 8'h33; p_stall = 1'b1;
    #1;
    checkOutput("pt_ready_stall", 32'(p_ready), 32'd0);
    checkOutput("pt_data_22", 32'(p_odata), 32'h22);
    checkOutput("pt_count_max", 32'(p_count), 32'd1);
    nextCycle();
    p_iv = 1'b0; p_stall = 1'b0; p_ordy = 1'b0;
    #1;
    checkOutput("pt_hold_22", 32'(p_odata), 32'h22);
    checkOutput("pt_ready_low", 32'(p_ready), 32'd0);
    p_ordy = 1'b1;
    #1;
    checkOutput("pt_ready_high", 32'(p_ready), 32'd1);
    nextCycle();
    p_ordy = 1'b0;
    #1;
    checkOutput("pt_drained", 32'(p_valid), 32'd0);

    // Random traffic on both instances from a common reset.
    idleSkid(1'b1);
    idlePass(1'b1);
    nextCycle();
    sq.delete();
    pq.delete();
    for (int c = 0; c < 800; c++) applyStimulus(c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk samples all state on its rising edge, and rst is sampled only at that edge.
REQ-002 Parameter DATA_W, default 32: width of the payload word (concatenated stage fields), legal range 1..256.
REQ-003 Parameter SKID_EN, default 1: 1 = two-entry skid stage with registered in_ready_o; 0 = single-entry stage with pass-through ready.
REQ-004 Parameter RESET_DATA, default 0 (DATA_W bits): value loaded into all payload registers on reset.
REQ-005 Ports (name  direction  width  meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  stall_i  in  1  freeze: no transfer on either side this cycle
  flush_i  in  1  discard all held entries
  in_valid_i  in  1  upstream word present
  in_ready_o  out  1  stage accepts a word this cycle
  in_data_i  in  DATA_W  upstream payload
  out_valid_o  out  1  downstream word present
  out_ready_i  in  1  downstream accepts
  out_data_o  out  DATA_W  downstream payload
  count_o  out  2  entries held (0..2)

Function
REQ-006 Internal state SHALL be a main entry (main_v, main_d), a skid entry (skid_v, skid_d), and an occupancy state EMPTY / ONE / FULL (count_o = 0 / 1 / 2).
REQ-007 out_valid_o SHALL equal main_v, and out_data_o SHALL equal main_d.
REQ-008 in_fire SHALL be in_valid_i & in_ready_o, and out_fire SHALL be out_valid_o & out_ready_i & ~stall_i.
REQ-009 SKID_EN=1: in_ready_o SHALL be ~skid_v & ~stall_i, with no combinational path from out_ready_i.
REQ-010 SKID_EN=0: in_ready_o SHALL be (~main_v | out_ready_i) & ~stall_i, and FULL SHALL be unreachable.
REQ-011 EMPTY state transitions:
  - in_fire -> ONE, main_d <= in_data_i.
  - Otherwise stay in EMPTY.
REQ-012 ONE state transitions:
  - in_fire & out_fire -> ONE, main_d <= in_data_i.
  - in_fire only -> FULL (SKID_EN=1), skid_d <= in_data_i, main_d unchanged.
  - out_fire only -> EMPTY.
REQ-013 FULL state transitions:
  - out_fire -> ONE, main_d <= skid_d.
  - No input is accepted in FULL.
REQ-014 Ordering SHALL be strict FIFO: words SHALL leave in acceptance order with no loss and no duplication.
REQ-015 Latency SHALL be 1 cycle: a word accepted at edge N SHALL be visible on out_data_o after edge N when the stage was EMPTY, or when it was ONE with a simultaneous out_fire.
REQ-016 While stall_i=1:
  - All registers SHALL hold.
  - out_valid_o and out_data_o SHALL stay visible.
  - in_ready_o SHALL be 0.
REQ-017 flush_i=1 at an edge SHALL force EMPTY (main_v = skid_v = 0).
  - Any concurrent in_fire SHALL be dropped.
  - Payload registers are not required to change.
  - flush_i SHALL override stall_i.
REQ-018 A payload register SHALL be written only on the transitions listed above, so out_data_o SHALL stay stable while out_valid_o=1 and out_fire=0.
REQ-019 The block SHALL produce no X on any output after the first reset edge, for any input sequence.

Reset
REQ-020 With rst=1 at an edge, the next state SHALL be:
  - main_v = skid_v = 0, count_o = 0.
  - main_d = skid_d = RESET_DATA.
  - out_valid_o = 0, out_data_o = RESET_DATA.
REQ-021 rst SHALL take priority over flush_i, stall_i and any handshake; a mid-transfer word in that cycle SHALL be discarded.
REQ-022 In the cycle after reset release, in_ready_o SHALL be 1 when stall_i=0.

Verification
REQ-023 Streaming (SKID_EN=1, DATA_W=32): drive 0x1..0x8 back-to-back with out_ready_i=1 -> outputs 0x1..0x8 in order, one per cycle, each one cycle after input, count_o=1 throughout.
REQ-024 Backpressure: accept 0xA then 0xB with out_ready_i=0 -> count_o=2, in_ready_o=0, out_data_o=0xA held; raise out_ready_i -> 0xA, then 0xB, then count_o=0.
REQ-025 Stall: in FULL holding 0xA/0xB, assert stall_i for 3 cycles with out_ready_i=1 -> no change, out_data_o=0xA, in_ready_o=0; release -> drains normally.
REQ-026 Flush: in FULL, assert flush_i together with in_valid_i=1 carrying 0xC -> next cycle count_o=0, out_valid_o=0, and 0xC never appears.
REQ-027 Reset and pass-through mode:
  - Assert rst in FULL with RESET_DATA=0x5A -> out_valid_o=0, out_data_o=0x5A.
  - With SKID_EN=0, in_ready_o follows out_ready_i combinationally while main_v=1, and count_o never exceeds 1.
